// File: rtl/lfsr_timeout_ctrl.sv
// ---------------------------------------------------------------------------
// lfsr_timeout_ctrl
//
// Control stage in front of a 4-bit LFSR expiry counter. A timeout request
// is accepted on a valid/ready handshake. The accepted seed is preset into
// the counter for one LOAD cycle. The block then counts ctr_expired events
// until the requested number of expirations is reached, and signals
// completion with a one-cycle done pulse. In periodic mode the counter is
// re-preset after every completion until the timeout is aborted.
//
// Ports:
//   clk             single clock, rising edge
//   resetb          asynchronous active-low reset
//   req_valid       request present
//   req_ready       request can be accepted (IDLE only)
//   req_seed        seed to preset into the counter
//   req_reps        expirations to wait for (0 behaves as 1)
//   req_periodic    re-arm automatically after each completion
//   abort           cancel an active timeout (ignored in IDLE)
//   new_cntr_preset preset strobe to the counter (high during LOAD)
//   seed            seed to the counter; holds the last accepted seed
//   ctr_expired     expiry flag from the counter
//   busy            timeout active (LOAD or RUN)
//   done            one-cycle completion pulse
//   aborted         one-cycle pulse when an active timeout is cancelled
//   exp_cnt         expirations counted in the current run
// ---------------------------------------------------------------------------
module lfsr_timeout_ctrl #(
  parameter int unsigned REP_W = 4
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_seed,
  input  logic [REP_W-1:0] req_reps,
  input  logic             req_periodic,
  input  logic             abort,
  output logic             new_cntr_preset,
  output logic [3:0]       seed,
  input  logic             ctr_expired,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [REP_W-1:0] exp_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       seed_q, seed_d;
  logic [REP_W-1:0] target_q, target_d;
  logic             periodic_q, periodic_d;
  logic [REP_W-1:0] cnt_q, cnt_d;
  logic             preset_q, preset_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;

  logic [REP_W-1:0] cnt_inc;

  assign cnt_inc = cnt_q + REP_W'(1);

  always_comb begin
    // NOTE: every next-state value gets a default before the case statement,
    // so no path leaves a variable unassigned and no latch is inferred.
    state_d    = state_q;
    seed_d     = seed_q;
    target_d   = target_q;
    periodic_d = periodic_q;
    cnt_d      = cnt_q;
    preset_d   = 1'b0;
    done_d     = 1'b0;
    aborted_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // abort has no meaning here; a simultaneous request is still taken.
        if (req_valid) begin
          seed_d     = req_seed;
          target_d   = (req_reps == '0) ? REP_W'(1) : req_reps;
          periodic_d = req_periodic;
          cnt_d      = '0;
          preset_d   = 1'b1;
          state_d    = ST_LOAD;
        end
      end

      ST_LOAD: begin
        // The counter still holds its old value this cycle, so its expiry
        // flag is not meaningful and is ignored.
        if (abort) begin
          aborted_d  = 1'b1;
          periodic_d = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        // abort wins over a completing expiry: no done, count unchanged.
        if (abort) begin
          aborted_d  = 1'b1;
          periodic_d = 1'b0;
          state_d    = ST_IDLE;
        end else if (ctr_expired && (cnt_q != target_q)) begin
          if (cnt_inc == target_q) begin
            done_d = 1'b1;
            if (periodic_q) begin
              cnt_d    = '0;
              preset_d = 1'b1;
              state_d  = ST_LOAD;
            end else begin
              cnt_d   = cnt_inc;
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q    <= ST_IDLE;
      seed_q     <= 4'hF;
      target_q   <= '0;
      periodic_q <= 1'b0;
      cnt_q      <= '0;
      preset_q   <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      seed_q     <= seed_d;
      target_q   <= target_d;
      periodic_q <= periodic_d;
      cnt_q      <= cnt_d;
      preset_q   <= preset_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
    end
  end

  assign req_ready       = (state_q == ST_IDLE);
  assign busy            = (state_q != ST_IDLE);
  assign new_cntr_preset = preset_q;
  assign seed            = seed_q;
  assign done            = done_q;
  assign aborted         = aborted_q;
  assign exp_cnt         = cnt_q;

endmodule

// File: tb/tb_lfsr_timeout_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lfsr_timeout_ctrl
//
// Self-checking bench for lfsr_timeout_ctrl. A behavioural model predicts
// all outputs from the handshake/expiry/abort rules; a compare process
// checks the DUT against it on every falling edge. Directed scenarios pin
// the model with hand-computed literals, then a randomized phase exercises
// arbitrary interleavings of requests, expiries and aborts.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_lfsr_timeout_ctrl;

  localparam int REP_W = 4;

  logic             clk;
  logic             resetb;
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_seed;
  logic [REP_W-1:0] req_reps;
  logic             req_periodic;
  logic             abort;
  logic             new_cntr_preset;
  logic [3:0]       seed;
  logic             ctr_expired;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [REP_W-1:0] exp_cnt;

  int n_checks = 0;
  int n_errors = 0;

  lfsr_timeout_ctrl #(.REP_W(REP_W)) dut (
    .clk             (clk),
    .resetb          (resetb),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_seed        (req_seed),
    .req_reps        (req_reps),
    .req_periodic    (req_periodic),
    .abort           (abort),
    .new_cntr_preset (new_cntr_preset),
    .seed            (seed),
    .ctr_expired     (ctr_expired),
    .busy            (busy),
    .done            (done),
    .aborted         (aborted),
    .exp_cnt         (exp_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Behavioural model. Activity is described as "no timeout", "presetting"
  // or "counting"; the expected outputs follow from those rules directly.
  // -------------------------------------------------------------------------
  bit m_active;     // a timeout is in progress
  bit m_presetting; // this cycle is the preset cycle of the timeout
  int m_target;
  bit m_periodic;
  int m_count;
  int m_seed;
  bit m_done;
  bit m_aborted;

  always @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      m_active = 0; m_presetting = 0; m_target = 0; m_periodic = 0;
      m_count = 0; m_seed = 15; m_done = 0; m_aborted = 0;
    end else begin
      m_done = 0;
      m_aborted = 0;
      if (!m_active) begin
        if (req_valid) begin
          m_seed = int'(req_seed);
          m_target = (req_reps == 0) ? 1 : int'(req_reps);
          m_periodic = req_periodic;
          m_count = 0;
          m_active = 1;
          m_presetting = 1;
        end
      end else if (abort) begin
        m_aborted = 1;
        m_periodic = 0;
        m_active = 0;
        m_presetting = 0;
      end else if (m_presetting) begin
        m_presetting = 0;
      end else if (ctr_expired && m_count < m_target) begin
        m_count = m_count + 1;
        if (m_count == m_target) begin
          m_done = 1;
          if (m_periodic) begin
            m_count = 0;
            m_presetting = 1;
          end else begin
            m_active = 0;
          end
        end
      end
    end
  end

  // Compare process: all outputs are meaningful every cycle.
  always @(negedge clk) begin
    check("req_ready", int'(req_ready), int'(!m_active));
    check("busy", int'(busy), int'(m_active));
    check("new_cntr_preset", int'(new_cntr_preset), int'(m_presetting));
    check("seed", int'(seed), m_seed);
    check("done", int'(done), int'(m_done));
    check("aborted", int'(aborted), int'(m_aborted));
    check("exp_cnt", int'(exp_cnt), m_count);
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers
  // -------------------------------------------------------------------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic quiet();
    req_valid = 0; abort = 0; ctr_expired = 0; req_periodic = 0;
  endtask

  task automatic request(input logic [3:0] s, input logic [REP_W-1:0] r, input logic p);
    req_valid = 1; req_seed = s; req_reps = r; req_periodic = p;
  endtask

  int done_seen;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time limit %0t reached", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    resetb = 0; req_seed = 0; req_reps = 0;
    quiet();
    tick(); tick();
    resetb = 1;
    tick();
    check("lit_reset_seed", int'(seed), 15);
    check("lit_reset_ready", int'(req_ready), 1);

    // One-shot: seed 3, reps 2, expiries on RUN cycles 4 and 9.
    request(4'h3, 2, 0);
    tick();
    req_valid = 0;
    check("lit_os_preset", int'(new_cntr_preset), 1);
    check("lit_os_seed", int'(seed), 3);
    check("lit_os_busy", int'(busy), 1);
    tick();
    check("lit_os_preset_once", int'(new_cntr_preset), 0);
    for (int k = 1; k <= 9; k++) begin
      ctr_expired = (k == 4 || k == 9);
      tick();
      if (k == 4) check("lit_os_cnt1", int'(exp_cnt), 1);
    end
    ctr_expired = 0;
    check("lit_os_done", int'(done), 1);
    check("lit_os_busy_fall", int'(busy), 0);
    check("lit_os_cnt2", int'(exp_cnt), 2);
    tick();
    check("lit_os_done_pulse", int'(done), 0);
    check("lit_os_cnt_hold", int'(exp_cnt), 2);

    // reps=0 with expiry held high: LOAD-cycle expiry is masked.
    request(4'h5, 0, 0);
    ctr_expired = 1;
    tick();
    req_valid = 0;
    tick();
    check("lit_r0_no_load_count", int'(exp_cnt), 0);
    check("lit_r0_no_early_done", int'(done), 0);
    tick();
    ctr_expired = 0;
    check("lit_r0_done", int'(done), 1);
    check("lit_r0_cnt", int'(exp_cnt), 1);
    tick();

    // Periodic: reps 1, three expiries 5 cycles apart, then abort.
    request(4'h9, 1, 1);
    tick();
    req_valid = 0;
    req_periodic = 0;
    done_seen = 0;
    for (int n = 0; n < 3; n++) begin
      for (int w = 0; w < 4; w++) begin
        ctr_expired = 0;
        tick();
        check("lit_per_ready_low", int'(req_ready), 0);
      end
      ctr_expired = 1;
      tick();
      if (done) done_seen++;
      check("lit_per_preset_with_done", int'(new_cntr_preset), int'(done));
      check("lit_per_ready_low2", int'(req_ready), 0);
    end
    ctr_expired = 0;
    check("lit_per_done_count", done_seen, 3);
    tick();
    abort = 1;
    tick();
    abort = 0;
    check("lit_per_aborted", int'(aborted), 1);
    check("lit_per_idle", int'(req_ready), 1);
    tick();

    // Request accepted together with abort in IDLE; then abort on final expiry.
    request(4'hA, 2, 0);
    abort = 1;
    tick();
    quiet();
    check("lit_ab_accepted", int'(new_cntr_preset), 1);
    tick();
    ctr_expired = 1;
    tick();
    check("lit_ab_cnt1", int'(exp_cnt), 1);
    abort = 1;
    tick();
    quiet();
    check("lit_ab_aborted", int'(aborted), 1);
    check("lit_ab_no_done", int'(done), 0);
    check("lit_ab_cnt_held", int'(exp_cnt), 1);
    tick();

    // Back-pressure: valid held with a different seed while busy.
    request(4'h4, 1, 0);
    tick();
    req_seed = 4'h7;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("lit_bp_seed_kept", int'(seed), 4);
      check("lit_bp_not_ready", int'(req_ready), 0);
    end
    ctr_expired = 1;
    tick();
    check("lit_bp_done", int'(done), 1);
    check("lit_bp_seed_at_done", int'(seed), 4);
    tick();
    check("lit_bp_accept_after_done", int'(new_cntr_preset), 1);
    check("lit_bp_new_seed", int'(seed), 7);
    // Expiry still held: next acceptance exactly 3 cycles later.
    tick();
    tick();
    check("lit_b2b_done", int'(done), 1);
    tick();
    check("lit_b2b_reaccept", int'(new_cntr_preset), 1);
    quiet();
    tick(); tick(); tick();

    // Reset mid-RUN.
    request(4'h6, 3, 0);
    tick();
    req_valid = 0;
    tick();
    ctr_expired = 1;
    tick();
    ctr_expired = 0;
    check("lit_rst_precnt", int'(exp_cnt), 1);
    #2 resetb = 0;
    #1;
    check("lit_rst_ready", int'(req_ready), 1);
    check("lit_rst_preset", int'(new_cntr_preset), 0);
    check("lit_rst_seed", int'(seed), 15);
    check("lit_rst_busy", int'(busy), 0);
    check("lit_rst_done", int'(done), 0);
    check("lit_rst_aborted", int'(aborted), 0);
    check("lit_rst_cnt", int'(exp_cnt), 0);
    tick();
    resetb = 1;
    tick();

    // Randomized phase: the model and compare process judge every cycle.
    for (int c = 0; c < 2000; c++) begin
      req_valid    = ($urandom_range(0, 1) == 1);
      req_seed     = 4'($urandom);
      req_reps     = REP_W'($urandom_range(0, 3));
      req_periodic = ($urandom_range(0, 3) == 0);
      abort        = ($urandom_range(0, 15) == 0);
      ctr_expired  = ($urandom_range(0, 1) == 1);
      tick();
    end
    quiet();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
